// File: rtl/ccl_labeler_pkg.sv
// rtl/ccl_labeler_pkg.sv - shared types and constants for the connected-component labeler
package ccl_labeler_pkg;

  // How the label of a pixel was chosen
  typedef enum logic [1:0] {
    KIND_BG    = 2'd0,
    KIND_NEW   = 2'd1,
    KIND_COPY  = 2'd2,
    KIND_MERGE = 2'd3
  } label_kind_t;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } ccl_state_t;

  localparam int LABEL_BG = 0;

endpackage

// File: rtl/ccl_label_select.sv
// rtl/ccl_label_select.sv - picks label kind and min/max nonzero neighbour label
module ccl_label_select
  import ccl_labeler_pkg::*;
#(
  parameter int LABEL_W = 8,
  parameter int CONN8   = 1
) (
  input  logic               p,
  input  logic [LABEL_W-1:0] a,
  input  logic [LABEL_W-1:0] b,
  input  logic [LABEL_W-1:0] c,
  input  logic [LABEL_W-1:0] d,
  output label_kind_t        kind,
  output logic [LABEL_W-1:0] min_label,
  output logic [LABEL_W-1:0] max_label
);

  logic [LABEL_W-1:0] nb [4];

  // Diagonal neighbours only count under 8-connectivity; min/max ignore background
  always_comb begin
    nb[0] = (CONN8 != 0) ? a : '0;
    nb[1] = b;
    nb[2] = (CONN8 != 0) ? c : '0;
    nb[3] = d;
    min_label = '1;
    max_label = '0;
    for (int i = 0; i < 4; i++) begin
      if (nb[i] != '0) begin
        if (nb[i] < min_label) min_label = nb[i];
        if (nb[i] > max_label) max_label = nb[i];
      end
    end
    if (max_label == '0) min_label = '0;
    if (!p)                          kind = KIND_BG;
    else if (max_label == '0)        kind = KIND_NEW;
    else if (min_label == max_label) kind = KIND_COPY;
    else                             kind = KIND_MERGE;
  end

endmodule

// File: rtl/ccl_sdp_ram.sv
// rtl/ccl_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module ccl_sdp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write first in source order, but the read returns the pre-write contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ccl_labeler.sv
// rtl/ccl_labeler.sv - streaming connected-component labeler with union table and feature accumulators
module ccl_labeler
  import ccl_labeler_pkg::*;
#(
  parameter int LABEL_W = 8,
  parameter int COORD_W = 16,
  parameter int ACC_W   = 32,
  parameter int CONN8   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               p,
  input  logic [LABEL_W-1:0] A,
  input  logic [LABEL_W-1:0] B,
  input  logic [LABEL_W-1:0] C,
  input  logic [LABEL_W-1:0] D,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] q,
  output logic               overflow,
  output logic               busy,
  input  logic               rd_en,
  input  logic [LABEL_W-1:0] rd_label,
  output logic               rd_valid,
  output logic [ACC_W-1:0]   rd_area,
  output logic [ACC_W-1:0]   rd_sum_x,
  output logic [ACC_W-1:0]   rd_sum_y,
  output logic [LABEL_W-1:0] rd_parent
);

  localparam logic [LABEL_W-1:0] MAX_LABEL = '1;
  localparam int ACC_DW = 3 * ACC_W;

  ccl_state_t         state;
  logic [LABEL_W-1:0] clr_cnt, next_label, sel_min, sel_max, sel_label;
  logic               max_issued, stall, handshake, xfer, rd_accept;
  label_kind_t        sel_kind;
  logic               s1_valid, s1_fresh, s1_fg;
  logic [LABEL_W-1:0] s1_label;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic               acc_we, par_we, wr_q_valid;
  logic [LABEL_W-1:0] acc_waddr, raddr, raddr_q, wr_q_addr, par_waddr, par_wdata, par_rdata;
  logic [ACC_DW-1:0]  acc_wdata, acc_rdata, acc_cur, wr_q_data;

  ccl_label_select #(.LABEL_W(LABEL_W), .CONN8(CONN8)) u_sel (
    .p(p), .a(A), .b(B), .c(C), .d(D),
    .kind(sel_kind), .min_label(sel_min), .max_label(sel_max)
  );

  assign busy      = (state == ST_CLEAR);
  assign stall     = out_valid && !out_ready;
  assign in_ready  = (state == ST_RUN) && !stall;
  assign handshake = in_valid && in_ready;
  assign xfer      = handshake && !frame_start;
  assign rd_accept = rd_en && (state == ST_IDLE || state == ST_RUN) && !handshake;
  assign raddr     = xfer ? sel_label : rd_label;

  // A write issued on the same edge as the read is invisible to it, so bypass it
  assign acc_cur   = (wr_q_valid && wr_q_addr == raddr_q) ? wr_q_data : acc_rdata;
  assign rd_area   = acc_cur[ACC_W-1:0];
  assign rd_sum_x  = acc_cur[2*ACC_W-1:ACC_W];
  assign rd_sum_y  = acc_cur[3*ACC_W-1:2*ACC_W];
  assign rd_parent = par_rdata;

  // Label chosen for the incoming pixel
  always_comb begin
    case (sel_kind)
      KIND_NEW:              sel_label = next_label;
      KIND_COPY, KIND_MERGE: sel_label = sel_min;
      default:               sel_label = LABEL_W'(LABEL_BG);
    endcase
  end

  // Accumulator port: clear sweep, else one update the cycle after the read
  always_comb begin
    acc_we    = 1'b0;
    acc_waddr = s1_label;
    acc_wdata = {acc_cur[3*ACC_W-1:2*ACC_W] + ACC_W'(s1_y),
                 acc_cur[2*ACC_W-1:ACC_W] + ACC_W'(s1_x),
                 acc_cur[ACC_W-1:0] + ACC_W'(1)};
    if (busy) begin
      acc_we    = 1'b1;
      acc_waddr = clr_cnt;
      acc_wdata = '0;
    end else if (s1_fresh && s1_fg) begin
      acc_we = 1'b1;
    end
  end

  // Parent port: identity during clear, else record the larger label under the smaller
  always_comb begin
    par_we    = 1'b0;
    par_waddr = sel_max;
    par_wdata = sel_min;
    if (busy) begin
      par_we    = 1'b1;
      par_waddr = clr_cnt;
      par_wdata = clr_cnt;
    end else if (xfer && sel_kind == KIND_MERGE) begin
      par_we = 1'b1;
    end
  end

  ccl_sdp_ram #(.ADDR_W(LABEL_W), .DATA_W(ACC_DW)) u_acc_ram (
    .clk(clk), .we(acc_we), .waddr(acc_waddr), .wdata(acc_wdata),
    .raddr(raddr), .rdata(acc_rdata)
  );

  ccl_sdp_ram #(.ADDR_W(LABEL_W), .DATA_W(LABEL_W)) u_par_ram (
    .clk(clk), .we(par_we), .waddr(par_waddr), .wdata(par_wdata),
    .raddr(raddr), .rdata(par_rdata)
  );

  // Controller: frame_start always restarts the clear sweep
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else if (frame_start) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == MAX_LABEL) state <= ST_RUN;
    end
  end

  // Label allocator: saturates at the top label and flags reuse of it
  always_ff @(posedge clk) begin
    if (!reset_n || frame_start) begin
      next_label <= LABEL_W'(1);
      max_issued <= 1'b0;
      overflow   <= 1'b0;
    end else if (xfer && sel_kind == KIND_NEW) begin
      if (next_label != MAX_LABEL) next_label <= next_label + 1'b1;
      else if (max_issued)         overflow   <= 1'b1;
      else                         max_issued <= 1'b1;
    end
  end

  // Two-stage pipeline valids; the whole pipe freezes while the output is blocked
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_fresh  <= 1'b0;
      out_valid <= 1'b0;
      q         <= '0;
    end else if (frame_start) begin
      s1_valid  <= 1'b0;
      s1_fresh  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_fresh <= xfer;
      if (!stall) begin
        out_valid <= s1_valid;
        if (s1_valid) q <= s1_label;
        s1_valid <= xfer;
      end
    end
  end

  // Stage-1 payload captured on each accepted pixel
  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_label <= sel_label;
      s1_fg    <= p;
      s1_x     <= x;
      s1_y     <= y;
    end
  end

  // Read-address and last-write history for the accumulator bypass, plus readback valid
  always_ff @(posedge clk) begin
    raddr_q   <= raddr;
    wr_q_addr <= acc_waddr;
    wr_q_data <= acc_wdata;
    if (!reset_n) begin
      wr_q_valid <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      wr_q_valid <= acc_we;
      rd_valid   <= rd_accept;
    end
  end

endmodule

// File: doc/ccl_labeler.md
CCL_LABELER -- requirements
Module: ccl_labeler

Interface
REQ-001 Parameter LABEL_W, default 8: label width; label 0 = background; 2^LABEL_W table entries.
REQ-002 Parameter COORD_W, default 16: x/y coordinate width.
REQ-003 Parameter ACC_W, default 32: width of each feature accumulator.
REQ-004 Parameter CONN8, default 1: 1 = 8-connectivity (A,B,C,D); 0 = 4-connectivity (B,D only; A,C ignored).
REQ-005 clk  input  1  clock.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 frame_start  input  1  one-cycle pulse; starts table clear and label restart.
REQ-008 in_valid / in_ready  input / output  1 / 1  pixel handshake.
REQ-009 p  input  1  foreground pixel flag.
REQ-010 A, B, C, D  input  LABEL_W each  resolved neighbour labels (NW, N, NE, W).
REQ-011 x, y  input  COORD_W each  pixel coordinates.
REQ-012 out_valid / out_ready  output / input  1 / 1  label output handshake.
REQ-013 q  output  LABEL_W  label for the pixel.
REQ-014 overflow  output  1  sticky; label space exhausted.
REQ-015 busy  output  1  high while clearing.
REQ-016 rd_en, rd_label  input  1, LABEL_W  feature readback request.
REQ-017 rd_valid, rd_area, rd_sum_x, rd_sum_y, rd_parent  output  1, ACC_W x3, LABEL_W  readback data.

Function
REQ-018 FSM states: IDLE, CLEAR, RUN. Reset enters IDLE. frame_start from any state enters CLEAR. CLEAR exits to RUN after 2^LABEL_W cycles.
REQ-019 CLEAR: one entry per cycle, ascending from 0; accumulators set to 0; parent[i] set to i. busy=1 and in_ready=0 throughout.
REQ-020 in_ready = (state==RUN) && (out_ready || !out_valid). A transfer occurs when in_valid && in_ready.
REQ-021 Selection per transfer: p=0 -> label 0. All used neighbours 0 -> new label = next_label. All nonzero neighbours equal -> copy that label. Otherwise merge -> minimum nonzero label.
REQ-022 next_label resets to 1 on frame_start. It increments on each new label. It saturates at 2^LABEL_W-1.
REQ-023 A new-label request while next_label = 2^LABEL_W-1 and that value is already issued: assign 2^LABEL_W-1, set overflow; the counter does not wrap.
REQ-024 Merge: write parent[max nonzero label] = min nonzero label. Only max/min are recorded (one merge per neighbourhood).
REQ-025 Foreground pixel: add area+=1, sum_x+=x, sum_y+=y to the entry of the selected label. Additions wrap modulo 2^ACC_W.
REQ-026 Latency: q/out_valid 2 cycles after the input transfer when unstalled. The pipeline holds while out_valid && !out_ready. No output is dropped or duplicated.
REQ-027 Accumulator read-modify-write forwards in-flight updates. Back-to-back pixels with the same label accumulate exactly.
REQ-028 Readback is accepted only in IDLE or RUN with no transfer that cycle; otherwise it is ignored. rd_valid is asserted 1 cycle after acceptance with that entry's contents.
REQ-029 A frame_start with data in flight discards the in-flight data: out_valid=0 next cycle.

Reset
REQ-030 Reset values: state IDLE, out_valid 0, q 0, overflow 0, busy 0, rd_valid 0, next_label 1, all pipeline valids 0.
REQ-031 Table contents are undefined after reset until a CLEAR completes. Reset during CLEAR aborts to IDLE.

Structure
REQ-032 The shared package holds: label-kind enumeration (BG, NEW, COPY, MERGE), FSM state enumeration, and constant LABEL_BG = 0.
REQ-033 Tables use the existing simple dual-port ram block: one instance for parent, one for accumulators.
REQ-034 One sub-module, ccl_label_select: combinational selection of kind, label, min and max, parametrised by LABEL_W and CONN8.

Verification
REQ-035 frame_start, then hold in_valid=1 -> busy=1 for 256 cycles (LABEL_W=8), then in_ready=1. Readback of label 5 -> area 0, parent 5.
REQ-036 Pixels p=1, all neighbours 0, three times -> q = 1, 2, 3 two cycles after each transfer. Readback of 2 -> area 1.
REQ-037 CONN8=1, B=3, C=5, p=1 -> q=3 and parent[5]=3. CONN8=0 with the same inputs -> q=3 with no merge (C ignored).
REQ-038 Four consecutive pixels of label 4 at x = 10..13, y = 2 -> area 4, sum_x 46, sum_y 8.
REQ-039 LABEL_W=4, 16 new-label pixels -> labels 1..15, then 15 again; overflow=1 sticky until the next frame_start.
REQ-040 out_ready=0 for 5 cycles mid-stream -> in_ready drops. On release the outputs resume in order, with none lost or duplicated.
